// File: rtl/bn_stats_accumulator_pkg.sv
// Shared constants and state encoding for the batch-normalization statistics path.
// The batch-normalization stage imports this package too, so widths stay in lockstep.
package bn_stats_accumulator_pkg;

  localparam int BN_DATA_W       = 8;
  localparam int BN_CHANNELS     = 64;
  localparam int BN_LOG2_SAMPLES = 16;

  // Sized so that 2^LOG2_SAMPLES worst-case samples can never overflow.
  localparam int BN_SUM_W = BN_DATA_W + BN_LOG2_SAMPLES;
  localparam int BN_SQ_W  = 2 * BN_DATA_W + BN_LOG2_SAMPLES;
  localparam int BN_CH_W  = (BN_CHANNELS > 1) ? $clog2(BN_CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } bn_state_e;

endpackage

// File: rtl/bn_stats_finalize.sv
// Combinational reduction of one channel's (sum, sum of squares) into mean and
// saturated population variance.
module bn_stats_finalize
  import bn_stats_accumulator_pkg::*;
#(
  parameter int DATA_W       = BN_DATA_W,
  parameter int LOG2_SAMPLES = BN_LOG2_SAMPLES,
  localparam int SUM_W       = DATA_W + LOG2_SAMPLES,
  localparam int SQ_W        = 2 * DATA_W + LOG2_SAMPLES
) (
  input  logic [SUM_W-1:0]  sum,
  input  logic [SQ_W-1:0]   sq,
  output logic [DATA_W-1:0] mean,
  output logic [DATA_W-1:0] variance
);

  logic [2*DATA_W-1:0]       mean_ext;
  logic [2*DATA_W-1:0]       mean_sq;
  logic [2*DATA_W-1:0]       sq_avg;
  logic [2*DATA_W-1:0]       var_raw;
  logic [2*LOG2_SAMPLES-1:0] unused_low;

  // Both terms are floored averages, so the difference can never go negative.
  always_comb begin
    mean     = sum[SUM_W-1:LOG2_SAMPLES];
    sq_avg   = sq[SQ_W-1:LOG2_SAMPLES];
    mean_ext = {{DATA_W{1'b0}}, mean};
    mean_sq  = mean_ext * mean_ext;
    var_raw  = sq_avg - mean_sq;
    variance = (|var_raw[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}} : var_raw[DATA_W-1:0];
  end

  assign unused_low = {sum[LOG2_SAMPLES-1:0], sq[LOG2_SAMPLES-1:0]};

endmodule

// File: rtl/bn_stats_accumulator.sv
// Streams channel-interleaved samples, accumulates per-channel sum / sum of squares,
// then emits one (channel, mean, variance) record per channel on a valid/ready port.
module bn_stats_accumulator
  import bn_stats_accumulator_pkg::*;
#(
  parameter int DATA_W       = BN_DATA_W,
  parameter int CHANNELS     = BN_CHANNELS,
  parameter int LOG2_SAMPLES = BN_LOG2_SAMPLES,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_channel,
  output logic [DATA_W-1:0] out_mean,
  output logic [DATA_W-1:0] out_variance,
  output logic              busy,
  output logic              done
);

  localparam int SUM_W = DATA_W + LOG2_SAMPLES;
  localparam int SQ_W  = 2 * DATA_W + LOG2_SAMPLES;
  localparam logic [CH_W-1:0]         CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [LOG2_SAMPLES-1:0] PASS_LAST = {LOG2_SAMPLES{1'b1}};

  bn_state_e                 state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [LOG2_SAMPLES-1:0]   pass_q, pass_d;
  logic                      out_valid_q, out_valid_d;
  logic [CH_W-1:0]           out_channel_q, out_channel_d;
  logic [DATA_W-1:0]         out_mean_q, out_mean_d;
  logic [DATA_W-1:0]         out_var_q, out_var_d;
  logic                      done_q, done_d;

  logic                      beat;
  logic                      load_rec;

  logic [SUM_W-1:0]          sum_mem [CHANNELS];
  logic [SQ_W-1:0]           sq_mem  [CHANNELS];

  logic [2*DATA_W-1:0]       x_wide;
  logic [2*DATA_W-1:0]       x_sq;
  logic [SUM_W-1:0]          x_sum_ext;
  logic [SQ_W-1:0]           x_sq_ext;
  logic [SUM_W-1:0]          sum_new;
  logic [SQ_W-1:0]           sq_new;

  logic [CH_W-1:0]           rd_ch;
  logic                      rd_fwd;
  logic [SUM_W-1:0]          rd_sum;
  logic [SQ_W-1:0]           rd_sq;
  logic [DATA_W-1:0]         fin_mean;
  logic [DATA_W-1:0]         fin_var;

  // Pass 0 overwrites rather than adds, so no clearing sweep is needed between batches.
  always_comb begin
    x_wide    = {{DATA_W{1'b0}}, in_data};
    x_sq      = x_wide * x_wide;
    x_sum_ext = '0;
    x_sum_ext[DATA_W-1:0] = in_data;
    x_sq_ext  = '0;
    x_sq_ext[2*DATA_W-1:0] = x_sq;
    if (pass_q == '0) begin
      sum_new = x_sum_ext;
      sq_new  = x_sq_ext;
    end else begin
      sum_new = sum_mem[ch_q] + x_sum_ext;
      sq_new  = sq_mem[ch_q] + x_sq_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      sum_mem[ch_q] <= sum_new;
      sq_mem[ch_q]  <= sq_new;
    end
  end

  // Record source: channel 0 when leaving ACCUM, otherwise the next channel.
  // The forward covers CHANNELS==1, where channel 0 is written on the last beat.
  always_comb begin
    if (state_q == ACCUM || out_channel_q == CH_LAST) begin
      rd_ch = '0;
    end else begin
      rd_ch = out_channel_q + 1'b1;
    end
    rd_fwd = beat && (ch_q == rd_ch);
    rd_sum = rd_fwd ? sum_new : sum_mem[rd_ch];
    rd_sq  = rd_fwd ? sq_new  : sq_mem[rd_ch];
  end

  bn_stats_finalize #(
    .DATA_W       (DATA_W),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_finalize (
    .sum      (rd_sum),
    .sq       (rd_sq),
    .mean     (fin_mean),
    .variance (fin_var)
  );

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    pass_d        = pass_q;
    out_valid_d   = out_valid_q;
    out_channel_d = out_channel_q;
    out_mean_d    = out_mean_q;
    out_var_d     = out_var_q;
    done_d        = 1'b0;
    beat          = 1'b0;
    load_rec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          ch_d    = '0;
          pass_d  = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          beat = 1'b1;
          if (ch_q == CH_LAST) begin
            ch_d   = '0;
            pass_d = pass_q + 1'b1;
            if (pass_q == PASS_LAST) begin
              state_d       = EMIT;
              out_valid_d   = 1'b1;
              out_channel_d = '0;
              load_rec      = 1'b1;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_channel_q == CH_LAST) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            out_channel_d = out_channel_q + 1'b1;
            load_rec      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_rec) begin
      out_mean_d = fin_mean;
      out_var_d  = fin_var;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      pass_q        <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_mean_q    <= '0;
      out_var_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      pass_q        <= pass_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_mean_q    <= out_mean_d;
      out_var_q     <= out_var_d;
      done_q        <= done_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign busy         = (state_q == ACCUM) || (state_q == EMIT);
  assign out_valid    = out_valid_q;
  assign out_channel  = out_channel_q;
  assign out_mean     = out_mean_q;
  assign out_variance = out_var_q;
  assign done         = done_q;

endmodule

// File: tb/tb_bn_stats_accumulator.sv
// Directed bench for bn_stats_accumulator with 4 channels and 4 samples per channel.
module tb_bn_stats_accumulator;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int L2 = 2;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_channel;
  logic [DW-1:0] out_mean;
  logic [DW-1:0] out_variance;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] samp     [CH][NS];
  logic [DW-1:0] exp_mean [CH];
  logic [DW-1:0] exp_var  [CH];

  bn_stats_accumulator #(
    .DATA_W       (DW),
    .CHANNELS     (CH),
    .LOG2_SAMPLES (L2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_channel  (out_channel),
    .out_mean     (out_mean),
    .out_variance (out_variance),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_uniform(input logic [DW-1:0] v);
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < NS; p++) samp[c][p] = v;
      exp_mean[c] = v;
      exp_var[c]  = 8'd0;
    end
  endtask

  // Starts a batch and feeds all beats; returns at the negedge after the last beat.
  task automatic send_batch(input bit gaps);
    int n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("in_ready_accum", in_ready, 1);
    check("busy_accum", busy, 1);
    for (int p = 0; p < NS; p++) begin
      for (int c = 0; c < CH; c++) begin
        if (gaps) begin
          n = $urandom_range(0, 2);
          in_valid = 1'b0;
          repeat (n) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = samp[c][p];
        start    = gaps && (p == 1) && (c == 2);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_rec(input int c, input string tag);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_chan"}, out_channel, c);
    check({tag, "_mean"}, out_mean, exp_mean[c]);
    check({tag, "_var"}, out_variance, exp_var[c]);
  endtask

  task automatic collect(input int stall);
    for (int c = 0; c < CH; c++) begin
      if (c == 0) begin
        for (int k = 0; k < stall; k++) begin
          out_ready = 1'b0;
          check_rec(0, "rec_stall");
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check_rec(c, "rec");
      check("in_ready_emit", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("valid_drop", out_valid, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_out_mean", out_mean, 0);
    check("rst_out_variance", out_variance, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform 10s: zero variance everywhere.
    set_uniform(8'd10);
    send_batch(1'b0);
    collect(0);
    $display("[TB] batch uniform10 complete");

    // Mixed pattern, including a saturating channel.
    set_uniform(8'd10);
    samp[1][0] = 8'd0;  samp[1][1] = 8'd2;  samp[1][2] = 8'd0;  samp[1][3] = 8'd2;
    samp[2][0] = 8'd1;  samp[2][1] = 8'd2;  samp[2][2] = 8'd2;  samp[2][3] = 8'd2;
    samp[3][0] = 8'd0;  samp[3][1] = 8'd255; samp[3][2] = 8'd0; samp[3][3] = 8'd255;
    exp_mean[1] = 8'd1;   exp_var[1] = 8'd1;
    exp_mean[2] = 8'd1;   exp_var[2] = 8'd2;
    exp_mean[3] = 8'd127; exp_var[3] = 8'd255;
    send_batch(1'b0);
    collect(3);
    $display("[TB] batch mixed with 3-cycle stall complete");

    // Same data with input gaps and a stray start mid-ACCUM.
    send_batch(1'b1);
    collect(0);
    $display("[TB] batch mixed with gaps complete");

    // Partial batch of 200s aborted by reset.
    set_uniform(8'd200);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1;
      in_data  = 8'd200;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_out_valid", out_valid, 0);
    $display("[TB] reset mid-batch complete");

    set_uniform(8'd50);
    send_batch(1'b0);
    collect(0);
    $display("[TB] batch uniform50 after abort complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
